timekeeper_bcd: RTL and testbench
=================================

// Module: timekeeper_bcd
// PURPOSE
//  Parametrised BCD time-of-day core for the digital clock; successor to the fixed 24h timing block.
//  Adds an on-chip 1 Hz prescaler and a 12/24h mode.
//  Adds a validated set-time handshake, a programmable alarm with acknowledge, and a configurable hourly chime.
//  Feeds the display mux and the buzzer driver.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clk cycles per second (>=1; 1 for fast simulation)
//  MODE_24H       1           1: hours 00..23; 0: hours 12,01..11 with pm flag
//  CHIME_BEEPS    5           pre-hour beeps at even seconds of minute 59 (0..5)
//  QUIET_END_HR   7           chime muted for 24h-equivalent hours 00..QUIET_END_HR-1
//  ALARM_SECS     60          alarm ring duration in seconds (1..255)
// PORTS
//  clk          in   1   system clock, all state on posedge
//  reset        in   1   synchronous, active-high
//  set_valid    in   1   set-time request
//  set_ready    out  1   core can accept set-time
//  set_time     in   24  BCD {hh_h,hh_l,mm_h,mm_l,ss_h,ss_l}; 12h mode uses 01..12
//  set_pm       in   1   pm flag for set_time (ignored if MODE_24H=1)
//  set_err      out  1   1-cycle pulse: rejected set_time
//  alarm_time   in   17  {pm, BCD hh, BCD mm}; pm ignored if MODE_24H=1
//  alarm_arm    in   1   alarm enable level
//  alarm_ack    in   1   stops ringing alarm
//  chime_en     in   1   chime enable level
//  time_o       out  24  current time, BCD, same packing as set_time
//  pm_o         out  1   pm flag (0 when MODE_24H=1)
//  sec_pulse    out  1   1-cycle pulse on each second increment
//  chime        out  1   chime drive
//  alarm_ring   out  1   alarm drive
// BEHAVIOUR
//  Reset: time_o=00:00:00 (24h) or 12:00:00 with pm_o=0 (12h); prescaler=0; set_ready=1.
//  Reset: set_err=0, sec_pulse=0, chime=0, alarm_ring=0; FSM -> RUN.
//  Prescaler: counts 0..TICKS_PER_SEC-1. At terminal count, sec_pulse=1 that cycle and time increments on the same edge.
//  Increment: ss 59->00 carries to mm; mm 59->00 carries to hh.
//  24h increment: 23:59:59->00:00:00.
//  12h increment: 11:59:59->12:00:00 toggles pm_o; 12:59:59->01:00:00; pm_o unchanged otherwise.
//  FSM RUN/LOAD/ERR:
//   RUN: set_ready=1; accept on set_valid&&set_ready.
//   Valid accept -> LOAD. Invalid accept -> ERR.
//   Invalid: any digit >9, ss/mm >59, hh >23 (24h), hh 00 or >12 (12h).
//   LOAD: one cycle; time_o/pm_o <= captured value; prescaler cleared; set_ready=0; -> RUN.
//   ERR: one cycle; set_err=1, time unchanged, set_ready=0; -> RUN.
//   Accept cycle coinciding with terminal count: the tick is dropped; loaded value wins.
//  Chime (registered, 1 cycle after time_o):
//   chime=1 when chime_en && !quiet && (mm==59 && ss even && ss>=60-2*CHIME_BEEPS || mm==00 && ss==00).
//   Quiet hours use the 24h-equivalent hour (12 AM=0).
//  Alarm trigger: second increment landing on ss==00 with alarm_arm, where hh:mm(:pm) == alarm_time.
//   A LOAD never triggers the alarm.
//   On trigger: alarm_ring=1; ring-second counter=ALARM_SECS.
//  Alarm while ringing: counter decrements per sec_pulse. alarm_ring drops when the counter hits 0, on alarm_ack, or on alarm_arm=0.
//   ack on the trigger cycle wins; the alarm does not ring.
//  Reset mid-ring or mid-LOAD: everything returns to reset values next edge.
// TESTING
//  TICKS=1, 24h, load 23:59:58 -> 2 sec_pulses later time_o=00:00:00.
//  12h, load 11:59:59 pm=0 -> next tick 12:00:00 pm_o=1; load 12:59:59 -> 01:00:00.
//  Load 24:00:00 (24h) or 07:6A:00 -> set_err 1 cycle, time_o unchanged, set_ready low 1 cycle.
//  Load 10:59:49, chime_en=1 -> chime on ss 50,52,54,56,58 and 11:00:00 only.
//  Load 03:59:49 -> chime stays 0 (quiet).
//  alarm 06:30, arm=1, load 06:29:59 -> ring at 06:30:00 for 60 s.
//  Rerun the alarm case with alarm_ack at 06:30:05 -> ring drops next edge.
//  set_valid on terminal-count cycle -> loaded value, prescaler restarts at 0.

Source files
------------

// File: rtl/timekeeper_bcd.sv
// BCD time-of-day core: 1 Hz prescaler, 12/24h counting, validated set-time
// handshake, alarm with acknowledge and an hourly chime.
module timekeeper_bcd #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MODE_24H      = 1,
    parameter int CHIME_BEEPS   = 5,
    parameter int QUIET_END_HR  = 7,
    parameter int ALARM_SECS    = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_valid,
    output logic        set_ready,
    input  logic [23:0] set_time,
    input  logic        set_pm,
    output logic        set_err,
    input  logic [16:0] alarm_time,
    input  logic        alarm_arm,
    input  logic        alarm_ack,
    input  logic        chime_en,
    output logic [23:0] time_o,
    output logic        pm_o,
    output logic        sec_pulse,
    output logic        chime,
    output logic        alarm_ring
);

    localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam bit            IS_24H     = (MODE_24H != 0);
    localparam logic [6:0]    CHIME_FROM = 7'(60 - 2 * CHIME_BEEPS);
    localparam logic [4:0]    QUIET_END  = 5'(QUIET_END_HR);
    localparam logic [7:0]    RING_SECS  = 8'(ALARM_SECS);
    localparam logic [7:0]    HH_RESET   = IS_24H ? 8'h00 : 8'h12;

    typedef enum logic [1:0] {RUN, LOAD, ERR} state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_bin(input logic [7:0] v);
        return {3'd0, v[7:4]} * 7'd10 + {3'd0, v[3:0]};
    endfunction

    function automatic logic set_ok(input logic [23:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++)
            if (t[4*i +: 4] > 4'd9) ok = 1'b0;
        if (t[7:4] > 4'd5 || t[15:12] > 4'd5) ok = 1'b0;
        if (IS_24H) begin
            if (t[23:16] > 8'h23) ok = 1'b0;
        end else if (t[23:16] == 8'h00 || t[23:16] > 8'h12) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    state_t        state;
    logic [PW-1:0] presc;
    logic [7:0]    hh, mm, ss;
    logic [7:0]    hh_nx, mm_nx, ss_nx;
    logic          pm_nx;
    logic [23:0]   cap_time;
    logic          cap_pm;
    logic [7:0]    ring_cnt;
    logic [4:0]    hour24;
    logic          accept, terminal, tick, alarm_hit, chime_hit;

    assign time_o    = {hh, mm, ss};
    assign accept    = set_valid && set_ready;
    assign terminal  = (presc == PRESC_LAST);
    // A second that coincides with a set request (or a LOAD/ERR cycle) is dropped.
    assign tick      = terminal && (state == RUN) && !accept && !reset;
    assign sec_pulse = tick;

    always_comb begin
        hh_nx = hh;
        mm_nx = mm;
        ss_nx = bcd_inc(ss);
        pm_nx = pm_o;
        if (ss == 8'h59) begin
            ss_nx = 8'h00;
            mm_nx = bcd_inc(mm);
            if (mm == 8'h59) begin
                mm_nx = 8'h00;
                if (IS_24H) begin
                    hh_nx = (hh == 8'h23) ? 8'h00 : bcd_inc(hh);
                end else if (hh == 8'h12) begin
                    hh_nx = 8'h01;
                end else begin
                    hh_nx = bcd_inc(hh);
                    if (hh == 8'h11) pm_nx = ~pm_o;
                end
            end
        end
    end

    // Alarm fires on the edge that lands on hh:mm:00, so compare the incremented time.
    assign alarm_hit = tick && alarm_arm && (ss_nx == 8'h00) &&
                       (hh_nx == alarm_time[15:8]) && (mm_nx == alarm_time[7:0]) &&
                       (IS_24H || (pm_nx == alarm_time[16]));

    always_comb begin
        hour24 = 5'(bcd_bin(hh));
        if (!IS_24H) begin
            if (hh == 8'h12) hour24 = 5'd0;
            if (pm_o) hour24 = hour24 + 5'd12;
        end
    end

    assign chime_hit = chime_en && (hour24 >= QUIET_END) &&
                       ((mm == 8'h59 && !ss[0] && bcd_bin(ss) >= CHIME_FROM) ||
                        (mm == 8'h00 && ss == 8'h00));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            set_ready  <= 1'b1;
            set_err    <= 1'b0;
            presc      <= '0;
            hh         <= HH_RESET;
            mm         <= 8'h00;
            ss         <= 8'h00;
            pm_o       <= 1'b0;
            cap_time   <= '0;
            cap_pm     <= 1'b0;
            chime      <= 1'b0;
            alarm_ring <= 1'b0;
            ring_cnt   <= '0;
        end else begin
            set_err <= 1'b0;
            chime   <= chime_hit;
            presc   <= terminal ? '0 : presc + 1'b1;
            if (tick) begin
                hh   <= hh_nx;
                mm   <= mm_nx;
                ss   <= ss_nx;
                pm_o <= pm_nx;
            end

            case (state)
                RUN: begin
                    if (accept) begin
                        cap_time  <= set_time;
                        cap_pm    <= set_pm && !IS_24H;
                        set_ready <= 1'b0;
                        if (set_ok(set_time)) begin
                            state <= LOAD;
                        end else begin
                            state   <= ERR;
                            set_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    hh        <= cap_time[23:16];
                    mm        <= cap_time[15:8];
                    ss        <= cap_time[7:0];
                    pm_o      <= cap_pm;
                    presc     <= '0;
                    state     <= RUN;
                    set_ready <= 1'b1;
                end
                default: begin
                    state     <= RUN;
                    set_ready <= 1'b1;
                end
            endcase

            // An acknowledge on the trigger cycle suppresses the ring entirely.
            if (alarm_hit && !alarm_ack) begin
                alarm_ring <= 1'b1;
                ring_cnt   <= RING_SECS;
            end else if (alarm_ring) begin
                if (alarm_ack || !alarm_arm) begin
                    alarm_ring <= 1'b0;
                end else if (tick) begin
                    ring_cnt <= ring_cnt - 8'd1;
                    if (ring_cnt == 8'd1) alarm_ring <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_timekeeper_bcd.sv
// Scoreboard bench: a 24h instance (1 cycle/s) and a 12h instance (3 cycles/s)
// share stimulus and are checked against a seconds-of-day reference model.
module tb_timekeeper_bcd;

    localparam int TK0 = 1, TK1 = 3;
    localparam int BEEPS0 = 5, BEEPS1 = 3;
    localparam int ASECS0 = 60, ASECS1 = 4;
    localparam int QEND = 7;

    logic        clk = 1'b0;
    logic        reset, set_valid, set_pm, alarm_arm, alarm_ack, chime_en;
    logic [23:0] set_time;
    logic [16:0] alarm_time;

    logic [23:0] time0, time1;
    logic        rdy0, rdy1, err0, err1, pm0, pm1, sp0, sp1, ch0, ch1, rg0, rg1;
    logic [29:0] act0, act1;

    assign act0 = {time0, pm0, sp0, rdy0, err0, ch0, rg0};
    assign act1 = {time1, pm1, sp1, rdy1, err1, ch1, rg1};

    timekeeper_bcd #(.TICKS_PER_SEC(TK0), .MODE_24H(1), .CHIME_BEEPS(BEEPS0),
                     .QUIET_END_HR(QEND), .ALARM_SECS(ASECS0)) dut24 (
        .clk(clk), .reset(reset), .set_valid(set_valid), .set_ready(rdy0),
        .set_time(set_time), .set_pm(set_pm), .set_err(err0), .alarm_time(alarm_time),
        .alarm_arm(alarm_arm), .alarm_ack(alarm_ack), .chime_en(chime_en),
        .time_o(time0), .pm_o(pm0), .sec_pulse(sp0), .chime(ch0), .alarm_ring(rg0));

    timekeeper_bcd #(.TICKS_PER_SEC(TK1), .MODE_24H(0), .CHIME_BEEPS(BEEPS1),
                     .QUIET_END_HR(QEND), .ALARM_SECS(ASECS1)) dut12 (
        .clk(clk), .reset(reset), .set_valid(set_valid), .set_ready(rdy1),
        .set_time(set_time), .set_pm(set_pm), .set_err(err1), .alarm_time(alarm_time),
        .alarm_arm(alarm_arm), .alarm_ack(alarm_ack), .chime_en(chime_en),
        .time_o(time1), .pm_o(pm1), .sec_pulse(sp1), .chime(ch1), .alarm_ring(rg1));

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic        tmo;
        logic [29:0] e0;
        logic [29:0] e1;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_vec = 0, n_err = 0;
    bit   tmo_pend = 1'b0;

    // Model state: seconds of day, cycle within second, set phase (0 idle, 1 load, 2 err).
    int sod[2], cnt[2], ph[2], pend[2], left[2];
    bit chq[2], rg[2];

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [24:0] disp(input bit m24, input int s);
        int h, hd;
        h  = s / 3600;
        hd = m24 ? h : ((h % 12 == 0) ? 12 : h % 12);
        return {bcd(hd), bcd((s / 60) % 60), bcd(s % 60), (!m24 && h >= 12)};
    endfunction

    task automatic model_step();
        exp_t e;
        e = '0;
        e.chk = !reset;
        e.tmo = tmo_pend;
        tmo_pend = 1'b0;
        for (int m = 0; m < 2; m++) begin
            bit m24, tick, trig, chn, ok;
            int tk, beeps, asecs, h, mi, s, nsod, hr, amin;
            logic [29:0] v;
            m24   = (m == 0);
            tk    = m24 ? TK0 : TK1;
            beeps = m24 ? BEEPS0 : BEEPS1;
            asecs = m24 ? ASECS0 : ASECS1;
            tick  = (ph[m] == 0) && (cnt[m] == tk - 1) && !set_valid;
            v = {disp(m24, sod[m]), tick, ph[m] == 0, ph[m] == 2, chq[m], rg[m]};
            if (m24) e.e0 = v; else e.e1 = v;
            if (reset) begin
                sod[m] = 0; cnt[m] = 0; ph[m] = 0; chq[m] = 0; rg[m] = 0; left[m] = 0;
            end else begin
                h  = sod[m] / 3600;
                mi = (sod[m] / 60) % 60;
                s  = sod[m] % 60;
                chn = chime_en && h >= QEND &&
                      ((mi == 59 && s % 2 == 0 && s >= 60 - 2 * beeps) || (mi == 0 && s == 0));
                nsod = (sod[m] + 1) % 86400;
                hr   = bcd2i(alarm_time[15:8]);
                amin = (m24 ? hr : hr % 12 + (alarm_time[16] ? 12 : 0)) * 60 + bcd2i(alarm_time[7:0]);
                trig = tick && alarm_arm && (nsod % 60 == 0) && (nsod / 60 == amin);
                if (trig && !alarm_ack) begin
                    rg[m] = 1; left[m] = asecs;
                end else if (rg[m]) begin
                    if (alarm_ack || !alarm_arm) rg[m] = 0;
                    else if (tick) begin
                        left[m]--;
                        if (left[m] == 0) rg[m] = 0;
                    end
                end
                if (ph[m] == 1) begin
                    sod[m] = pend[m];
                    cnt[m] = 0;
                end else begin
                    if (tick) sod[m] = nsod;
                    cnt[m] = (cnt[m] == tk - 1) ? 0 : cnt[m] + 1;
                end
                if (ph[m] == 0 && set_valid) begin
                    ok = 1;
                    for (int k = 0; k < 6; k++)
                        if (set_time[4*k +: 4] > 4'd9) ok = 0;
                    hr = bcd2i(set_time[23:16]);
                    mi = bcd2i(set_time[15:8]);
                    s  = bcd2i(set_time[7:0]);
                    if (mi > 59 || s > 59) ok = 0;
                    if (m24 ? (hr > 23) : (hr < 1 || hr > 12)) ok = 0;
                    pend[m] = (m24 ? hr : hr % 12 + (set_pm ? 12 : 0)) * 3600 + mi * 60 + s;
                    ph[m] = ok ? 1 : 2;
                end else begin
                    ph[m] = 0;
                end
                chq[m] = chn;
            end
        end
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            if (mon_e.tmo) begin
                n_vec++;
                n_err++;
                $display("FAIL wait_bound @%0t: expected state not reached within bound", $time);
            end
            if (mon_e.chk) begin
                n_vec += 2;
                if (act0 !== mon_e.e0) begin
                    n_err++;
                    $display("FAIL out24 @%0t got=%h want=%h (time,pm,sp,rdy,err,chime,ring)",
                             $time, act0, mon_e.e0);
                end
                if (act1 !== mon_e.e1) begin
                    n_err++;
                    $display("FAIL out12 @%0t got=%h want=%h (time,pm,sp,rdy,err,chime,ring)",
                             $time, act1, mon_e.e1);
                end
            end
        end
    end

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input logic [23:0] t, input logic p);
        set_time  = t;
        set_pm    = p;
        set_valid = 1'b1;
        cycle();
        set_valid = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic wait_sod(input int m, input int target, input int bound);
        int k;
        k = 0;
        while (sod[m] != target && k < bound) begin
            cycle();
            k++;
        end
        if (sod[m] != target) tmo_pend = 1'b1;
    endtask

    function automatic logic [16:0] rand_alarm();
        return {1'($urandom_range(0, 1)), bcd($urandom_range(1, 12)), bcd($urandom_range(1, 59))};
    endfunction

    initial begin
        int k;
        reset = 1'b1; set_valid = 1'b0; set_time = '0; set_pm = 1'b0;
        alarm_time = '0; alarm_arm = 1'b0; alarm_ack = 1'b0; chime_en = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;
        run(3);

        load(24'h235958, 1'b0); run(4);
        load(24'h115959, 1'b0); run(6);
        load(24'h125959, 1'b1); run(6);
        load(24'h240000, 1'b0); run(2);
        load(24'h076A00, 1'b0); run(2);

        chime_en = 1'b1;
        load(24'h105949, 1'b0); run(70);
        load(24'h035949, 1'b0); run(70);
        chime_en = 1'b0;

        alarm_time = {1'b0, 8'h06, 8'h30};
        alarm_arm  = 1'b1;
        load(24'h062959, 1'b0); run(200);
        load(24'h062959, 1'b0);
        wait_sod(0, 6 * 3600 + 30 * 60 + 5, 20);
        alarm_ack = 1'b1; cycle(); alarm_ack = 1'b0;
        run(20);

        // Reset while ringing, then reset during the LOAD cycle.
        load(24'h062959, 1'b0); run(5);
        reset = 1'b1; cycle(); reset = 1'b0; run(3);
        set_time = 24'h123456; set_pm = 1'b1; set_valid = 1'b1; cycle();
        set_valid = 1'b0; reset = 1'b1; cycle(); reset = 1'b0; run(3);

        // Set request landing on the 12h instance's terminal-count cycle.
        k = 0;
        while (!(ph[1] == 0 && cnt[1] == TK1 - 1) && k < 10) begin
            cycle();
            k++;
        end
        if (!(ph[1] == 0 && cnt[1] == TK1 - 1)) tmo_pend = 1'b1;
        load(24'h081500, 1'b0); run(8);

        alarm_time = rand_alarm();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            set_valid = ($urandom_range(0, 11) == 0);
            set_pm = 1'($urandom_range(0, 1));
            if (r < 2) begin
                set_time = 24'($urandom());
            end else if (r < 5) begin
                set_time = {alarm_time[15:8], bcd(bcd2i(alarm_time[7:0]) - 1), bcd($urandom_range(55, 59))};
                set_pm = alarm_time[16];
            end else if (r < 7) begin
                set_time = {bcd($urandom_range(0, 23)), 8'h59, bcd($urandom_range(40, 59))};
            end else begin
                set_time = {bcd($urandom_range(0, 23)), bcd($urandom_range(0, 59)), bcd($urandom_range(0, 59))};
            end
            alarm_ack = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 150) == 0) alarm_arm = !alarm_arm;
            if ($urandom_range(0, 80) == 0) chime_en = !chime_en;
            if ($urandom_range(0, 400) == 0) alarm_time = rand_alarm();
            reset = ($urandom_range(0, 700) == 0);
            cycle();
        end

        reset = 1'b0; set_valid = 1'b0; alarm_ack = 1'b0;
        run(3);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
